// File: rtl/datapath_ctrl_if.sv
// Control/status bundle between the instruction controller (master) and the datapath (slave).
interface datapath_ctrl_if;
  logic        start;
  logic [31:0] ir;
  logic        busy;
  logic        lda;
  logic        ldb;
  logic        ldma;
  logic        ldiR;
  logic        reg_en;
  logic        mem_en;
  logic        alu_en;
  logic        IMM_en;
  logic        reg_we;
  logic        mem_we;
  logic [1:0]  reg_sel;
  logic [1:0]  ExtendSign_sel;
  logic [3:0]  ALUControl;
  logic        done;
  logic        err;
  logic [31:0] instret;

  modport master (
    input  start, ir, busy,
    output lda, ldb, ldma, ldiR, reg_en, mem_en, alu_en, IMM_en,
           reg_we, mem_we, reg_sel, ExtendSign_sel, ALUControl, done, err, instret
  );

  modport slave (
    output start, ir, busy,
    input  lda, ldb, ldma, ldiR, reg_en, mem_en, alu_en, IMM_en,
           reg_we, mem_we, reg_sel, ExtendSign_sel, ALUControl, done, err, instret
  );
endinterface

// File: rtl/datapath_ctrl.sv
// Multi-cycle instruction controller (R, I-ALU, LW, SW) for a single-bus datapath.
// Optional retired-instruction counter enabled by defining DATAPATH_CTRL_INSTRET_EN.
module datapath_ctrl (
  input  logic            clk,
  input  logic            rst,
  datapath_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, RS1, OPB, EXEC, MEM, DONE, ERR
  } state_t;

  typedef enum logic [1:0] {CLS_R, CLS_I, CLS_LW, CLS_SW} cls_t;

  typedef struct packed {
    logic       lda;
    logic       ldb;
    logic       ldma;
    logic       ldir;
    logic       reg_en;
    logic       mem_en;
    logic       alu_en;
    logic       imm_en;
    logic       reg_we;
    logic       mem_we;
    logic [1:0] reg_sel;
    logic [1:0] ext_sel;
    logic [3:0] alu_ctl;
    logic       done;
    logic       err;
    logic       stall;
  } ctrl_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;

  state_t state_q, state_d;
  cls_t   cls_q, cls_d, dec_cls;
  logic   dec_valid;
  ctrl_t  ctrl_q, ctrl_d;
  logic   stall_hold;
  logic   unused_ir;

  assign unused_ir = ^{bus.ir[31], bus.ir[29:15], bus.ir[11:7]};

  function automatic logic [3:0] alu_code(input logic [2:0] funct3, input logic f7,
                                          input logic is_r);
    logic [3:0] code;
    case (funct3)
      3'b000:  code = (is_r && f7) ? 4'b0110 : 4'b0010;
      3'b111:  code = 4'b0000;
      3'b110:  code = 4'b0001;
      3'b100:  code = 4'b0011;
      3'b010:  code = 4'b0111;
      3'b001:  code = 4'b0100;
      3'b101:  code = f7 ? 4'b1000 : 4'b0101;
      default: code = 4'b0000;
    endcase
    return code;
  endfunction

  always_comb begin
    dec_valid = 1'b1;
    dec_cls   = CLS_R;
    case (bus.ir[6:0])
      OP_R:    dec_cls = CLS_R;
      OP_I:    dec_cls = CLS_I;
      OP_LW:   dec_cls = CLS_LW;
      OP_SW:   dec_cls = CLS_SW;
      default: dec_valid = 1'b0;
    endcase
  end

  // Outputs are decoded from the next state so the registered strobes line up with the state.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = FETCH;
      FETCH:   if (!bus.busy) state_d = DECODE;
      DECODE: begin
        if (dec_valid) begin
          cls_d   = dec_cls;
          state_d = RS1;
        end else begin
          state_d = ERR;
        end
      end
      RS1:     state_d = OPB;
      OPB:     state_d = EXEC;
      EXEC:    state_d = (cls_q == CLS_R || cls_q == CLS_I) ? DONE : MEM;
      MEM:     if (!bus.busy) state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase

    ctrl_d = '0;
    case (state_d)
      FETCH: begin
        ctrl_d.mem_en = 1'b1;
        ctrl_d.ldir   = 1'b1;
        ctrl_d.stall  = 1'b1;
      end
      RS1: begin
        ctrl_d.reg_en = 1'b1;
        ctrl_d.lda    = 1'b1;
      end
      OPB: begin
        ctrl_d.ldb = 1'b1;
        if (cls_d == CLS_R) begin
          ctrl_d.reg_en  = 1'b1;
          ctrl_d.reg_sel = 2'b01;
        end else begin
          ctrl_d.imm_en  = 1'b1;
          ctrl_d.ext_sel = (cls_d == CLS_SW) ? 2'b01 : 2'b00;
        end
      end
      EXEC: begin
        ctrl_d.alu_en = 1'b1;
        if (cls_d == CLS_R || cls_d == CLS_I) begin
          ctrl_d.reg_we  = 1'b1;
          ctrl_d.reg_sel = 2'b10;
          ctrl_d.alu_ctl = alu_code(bus.ir[14:12], bus.ir[30], cls_d == CLS_R);
        end else begin
          ctrl_d.alu_ctl = 4'b0010;
          ctrl_d.ldma    = 1'b1;
        end
      end
      MEM: begin
        ctrl_d.stall = 1'b1;
        if (cls_d == CLS_LW) begin
          ctrl_d.mem_en  = 1'b1;
          ctrl_d.reg_we  = 1'b1;
          ctrl_d.reg_sel = 2'b10;
        end else begin
          ctrl_d.reg_en  = 1'b1;
          ctrl_d.reg_sel = 2'b01;
          ctrl_d.mem_we  = 1'b1;
        end
      end
      DONE:    ctrl_d.done = 1'b1;
      ERR:     ctrl_d.err  = 1'b1;
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cls_q   <= CLS_R;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Load/write strobes must drop in the same cycle memory reports busy, so they see busy live.
  assign stall_hold = ctrl_q.stall & bus.busy;

  assign bus.lda            = ctrl_q.lda;
  assign bus.ldb            = ctrl_q.ldb;
  assign bus.ldma           = ctrl_q.ldma;
  assign bus.ldiR           = ctrl_q.ldir & ~stall_hold;
  assign bus.reg_en         = ctrl_q.reg_en;
  assign bus.mem_en         = ctrl_q.mem_en;
  assign bus.alu_en         = ctrl_q.alu_en;
  assign bus.IMM_en         = ctrl_q.imm_en;
  assign bus.reg_we         = ctrl_q.reg_we & ~stall_hold;
  assign bus.mem_we         = ctrl_q.mem_we & ~stall_hold;
  assign bus.reg_sel        = ctrl_q.reg_sel;
  assign bus.ExtendSign_sel = ctrl_q.ext_sel;
  assign bus.ALUControl     = ctrl_q.alu_ctl;
  assign bus.done           = ctrl_q.done;
  assign bus.err            = ctrl_q.err;

`ifdef DATAPATH_CTRL_INSTRET_EN
  logic [31:0] instret_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instret_q <= '0;
    end else if (state_q == DONE) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  assign bus.instret = instret_q;
`else
  assign bus.instret = '0;
`endif
endmodule

// File: tb/tb_datapath_ctrl.sv
// Scoreboard bench for datapath_ctrl: per-cycle expected output vectors are queued at
// stimulus time and popped/compared on the falling edge.
module tb_datapath_ctrl;
  logic clk = 1'b0;
  logic rst;

  datapath_ctrl_if dp ();

  datapath_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (dp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       lda;
    logic       ldb;
    logic       ldma;
    logic       ldir;
    logic       reg_en;
    logic       mem_en;
    logic       alu_en;
    logic       imm_en;
    logic       reg_we;
    logic       mem_we;
    logic [1:0] reg_sel;
    logic [1:0] ext;
    logic [3:0] alu;
    logic       done;
    logic       err;
  } ov_t;

  localparam int K_R  = 0;
  localparam int K_I  = 1;
  localparam int K_LW = 2;
  localparam int K_SW = 3;

  int   checks = 0;
  int   errors = 0;
  ov_t  exp_q[$];
  logic busy_q[$];

  function automatic ov_t sample();
    ov_t o;
    o         = '0;
    o.lda     = dp.lda;
    o.ldb     = dp.ldb;
    o.ldma    = dp.ldma;
    o.ldir    = dp.ldiR;
    o.reg_en  = dp.reg_en;
    o.mem_en  = dp.mem_en;
    o.alu_en  = dp.alu_en;
    o.imm_en  = dp.IMM_en;
    o.reg_we  = dp.reg_we;
    o.mem_we  = dp.mem_we;
    o.reg_sel = dp.reg_sel;
    o.ext     = dp.ExtendSign_sel;
    o.alu     = dp.ALUControl;
    o.done    = dp.done;
    o.err     = dp.err;
    return o;
  endfunction

  // At most one bus driver in any cycle outside reset.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      checks++;
      if ((int'(dp.reg_en) + int'(dp.mem_en) + int'(dp.alu_en) + int'(dp.IMM_en)) > 1) begin
        errors++;
        $display("FAIL bus_onehot t=%0t: reg_en=%b mem_en=%b alu_en=%b IMM_en=%b, expected at most one",
                 $time, dp.reg_en, dp.mem_en, dp.alu_en, dp.IMM_en);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  task automatic run_instr(input string name, input logic [31:0] ir, input int kind,
                           input logic [3:0] alu, input int fstall, input int mstall,
                           input int exp_lat);
    ov_t e;
    ov_t o;
    int  lat;
    int  k;
    exp_q.delete();
    busy_q.delete();
    for (int i = 0; i <= fstall; i++) begin
      e = '0; e.mem_en = 1'b1; e.ldir = (i == fstall);
      exp_q.push_back(e); busy_q.push_back(i < fstall);
    end
    e = '0;
    exp_q.push_back(e); busy_q.push_back(1'b0);
    e = '0; e.reg_en = 1'b1; e.lda = 1'b1;
    exp_q.push_back(e); busy_q.push_back(1'b0);
    e = '0; e.ldb = 1'b1;
    if (kind == K_R) begin
      e.reg_en = 1'b1; e.reg_sel = 2'b01;
    end else begin
      e.imm_en = 1'b1; e.ext = (kind == K_SW) ? 2'b01 : 2'b00;
    end
    exp_q.push_back(e); busy_q.push_back(1'b0);
    e = '0; e.alu_en = 1'b1;
    if (kind == K_R || kind == K_I) begin
      e.reg_we = 1'b1; e.reg_sel = 2'b10; e.alu = alu;
    end else begin
      e.alu = 4'b0010; e.ldma = 1'b1;
    end
    exp_q.push_back(e); busy_q.push_back(1'b0);
    if (kind == K_LW || kind == K_SW) begin
      for (int i = 0; i <= mstall; i++) begin
        e = '0;
        if (kind == K_LW) begin
          e.mem_en = 1'b1; e.reg_sel = 2'b10; e.reg_we = (i == mstall);
        end else begin
          e.reg_en = 1'b1; e.reg_sel = 2'b01; e.mem_we = (i == mstall);
        end
        exp_q.push_back(e); busy_q.push_back(i < mstall);
      end
    end
    e = '0; e.done = 1'b1;
    exp_q.push_back(e); busy_q.push_back(1'b0);
    e = '0;
    exp_q.push_back(e); busy_q.push_back(1'b0);

    dp.ir    = ir;
    dp.busy  = 1'b0;
    dp.start = 1'b1;
    lat      = 0;
    k        = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      dp.start = 1'b0;
      dp.busy  = busy_q.pop_front();
      k++;
      @(negedge clk);
      e = exp_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s cycle %0d outputs: got %h expected %h", name, k, o, e);
      end
      if (o.done === 1'b1 && lat == 0) lat = k;
    end
    dp.busy = 1'b0;
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles expected %0d", name, lat, exp_lat);
    end
    $display("%s ir=%h done after %0d cycles", name, ir, lat);
  endtask

  task automatic test_reset();
    ov_t z;
    z        = '0;
    rst      = 1'b0;
    dp.start = 1'b1;
    dp.busy  = 1'b0;
    dp.ir    = 32'h002081B3;
    repeat (3) @(negedge clk);
    checks++;
    if (sample() !== z || dp.instret !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: outputs %h instret %h, expected all zero", sample(), dp.instret);
    end
    dp.start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    $display("reset released, outputs idle");
  endtask

  task automatic test_r_type();
    run_instr("add",       32'h002081B3, K_R, 4'b0010, 0, 0, 6);
    run_instr("sub",       32'h402081B3, K_R, 4'b0110, 0, 0, 6);
    run_instr("xor",       32'h0020C1B3, K_R, 4'b0011, 0, 0, 6);
    run_instr("add_fstall", 32'h002081B3, K_R, 4'b0010, 2, 0, 8);
  endtask

  task automatic test_i_alu();
    run_instr("addi", 32'h00700293, K_I, 4'b0010, 0, 0, 6);
    run_instr("srai", 32'h4030D293, K_I, 4'b1000, 0, 0, 6);
  endtask

  task automatic test_load_store();
    run_instr("lw_stall", 32'h0040A303, K_LW, 4'b0010, 0, 3, 10);
    run_instr("sw",       32'h0020A423, K_SW, 4'b0010, 0, 0, 7);
  endtask

  task automatic test_reset_mid();
    ov_t z;
    z        = '0;
    dp.ir    = 32'h002081B3;
    dp.start = 1'b1;
    @(posedge clk);
    #1 dp.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (dp.alu_en !== 1'b1 || dp.reg_we !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_exec: alu_en=%b reg_we=%b expected 1 1", dp.alu_en, dp.reg_we);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (sample() !== z || dp.instret !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_clear: outputs %h instret %h, expected all zero", sample(), dp.instret);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (dp.done !== 1'b0 || dp.reg_we !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_hold: done=%b reg_we=%b expected 0 0", dp.done, dp.reg_we);
      end
    end
    @(posedge clk);
    #1 rst = 1'b1;
    $display("reset during EXEC cleared all outputs");
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_ir;
`ifdef DATAPATH_CTRL_INSTRET_EN
    exp_ir = 32'd2;
`else
    exp_ir = 32'd0;
`endif
    run_instr("add_b2b_1", 32'h002081B3, K_R, 4'b0010, 0, 0, 6);
    run_instr("add_b2b_2", 32'h002081B3, K_R, 4'b0010, 0, 0, 6);
    checks++;
    if (dp.instret !== exp_ir) begin
      errors++;
      $display("FAIL instret: got %0d expected %0d", dp.instret, exp_ir);
    end
    $display("instret after two adds = %0d", dp.instret);
  endtask

  task automatic test_err();
    ov_t e;
    ov_t z;
    z        = '0;
    dp.ir    = 32'hFFFFFFFF;
    dp.start = 1'b1;
    @(posedge clk);
    #1 dp.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (sample() !== z) begin
      errors++;
      $display("FAIL err_decode: outputs %h expected %h", sample(), z);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 dp.start = (i == 2 || i == 3);
      @(negedge clk);
      e = '0; e.err = 1'b1;
      checks++;
      if (sample() !== e) begin
        errors++;
        $display("FAIL err_hold cycle %0d: outputs %h expected %h", i, sample(), e);
      end
    end
    dp.start = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (sample() !== z) begin
      errors++;
      $display("FAIL err_reset: outputs %h expected %h", sample(), z);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (dp.err !== 1'b0) begin
      errors++;
      $display("FAIL err_after_reset: err=%b expected 0", dp.err);
    end
    $display("illegal ir=ffffffff: err held until reset");
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_i_alu();
    test_load_store();
    test_reset_mid();
    test_back_to_back();
    test_err();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
